// File: rtl/p2s_stream_if.sv
// p2s_stream_if: bundle for the parallel-vector input and serial-beat output of p2s_stream.
// Latency: none; this is wiring only.
// Backpressure: in_ready throttles the vector producer, and out_ready throttles the beat stream.
interface p2s_stream_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 5,
  parameter int IDX_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  // Converter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/p2s_stream.sv
// p2s_stream: captures N_CH signed activations in one cycle and streams them out channel 0 first. Defining P2S_RELU_EN fuses a ReLU clamp at capture.
// Latency: the first beat appears 1 cycle after capture; a vector accepted on the last beat follows with no bubble.
// Backpressure: when out_ready is low the current beat is held; in_ready is low while a vector streams, except on its last beat.
module p2s_stream #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 5,
  parameter int IDX_W  = 4
) (
  input logic         clk,
  input logic         rst,
  p2s_stream_if.slave bus
);

  localparam int               VEC_W    = N_CH * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  generate
    if (N_CH < 2 || N_CH > 16 || (1 << IDX_W) < N_CH) begin : g_bad_param
      $error("p2s_stream: N_CH must be 2..16 and fit in IDX_W bits");
    end
  endgenerate

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  logic [VEC_W-1:0] hold_q;   // channels not yet presented, next one in the low slot
  logic [VEC_W-1:0] cap_vec;  // incoming vector after the optional clamp
  logic             accept;
  logic             advance;

  // Per-channel activation applied on the way into the buffer.
  function automatic logic [DATA_W-1:0] act_fn(input logic [DATA_W-1:0] x);
`ifdef P2S_RELU_EN
    return x[DATA_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Condition every channel of the incoming vector before it is buffered.
  always_comb begin
    cap_vec = '0;
    for (int k = 0; k < N_CH; k++) begin
      cap_vec[k*DATA_W +: DATA_W] = act_fn(bus.in_data[k*DATA_W +: DATA_W]);
    end
  end

  // A new vector may enter when idle, or on the final beat of the current vector.
  assign bus.in_ready = (state == IDLE) || (bus.out_valid && bus.out_ready && bus.out_last);
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = bus.out_valid && bus.out_ready;
  assign bus.busy     = (state == STREAM);

  // Two-state FSM with registered beat outputs.
  // A capture takes priority, because it only coincides with a transfer on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      state         <= STREAM;
      hold_q        <= cap_vec >> DATA_W;
      bus.out_valid <= 1'b1;
      bus.out_data  <= cap_vec[DATA_W-1:0];
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else if (advance) begin
      if (bus.out_last) begin
        state         <= IDLE;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end else begin
        hold_q        <= hold_q >> DATA_W;
        bus.out_data  <= hold_q[DATA_W-1:0];
        bus.out_idx   <= bus.out_idx + 1'b1;
        bus.out_last  <= (bus.out_idx + 1'b1) == LAST_IDX;
      end
    end
  end

endmodule
